subtractor_binary: RTL and testbench
====================================

SUBTRACTOR_BINARY -- requirements
Module: subtractor_binary

Interface
REQ-001 Parameter: WIDTH, default 2, operand width in bits; the default configuration SHALL be 2.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operands on a/b are valid this cycle.
REQ-005 Port: a  input  WIDTH  minuend A, unsigned; a[1]=a1 (MSB), a[0]=a0 (LSB).
REQ-006 Port: b  input  WIDTH  subtrahend B, unsigned; b[1]=b1 (MSB), b[0]=b0 (LSB).
REQ-007 Port: out_valid  output  1  sign/diff hold a result computed from a/b sampled while in_valid=1.
REQ-008 Port: sign  output  1  1 when A < B, else 0.
REQ-009 Port: diff  output  WIDTH  magnitude |A - B|, unsigned.

Function
REQ-010 Combinational core SHALL compute sign = (A < B) and mag = (A >= B) ? A-B : B-A, unsigned compare on WIDTH bits.
REQ-011 mag[0] SHALL equal a[0] XOR b[0] for all inputs.
REQ-012 For WIDTH=2, mag[1] SHALL be 1 exactly for (A,B) in {(0,2),(0,3),(1,3),(2,0),(3,0),(3,1)}.
REQ-013 For WIDTH=2, sign SHALL be 1 exactly for (A,B) in {(0,1),(0,2),(0,3),(1,2),(1,3),(2,3)}; in particular A=2,B=1 SHALL give sign=0.
REQ-014 A = B SHALL give sign=0, diff=0.
REQ-015 Latency SHALL be one clock: on a rising clk edge with in_valid=1, sign/diff register the core result for the sampled a/b and out_valid is set to 1.
REQ-016 On a rising clk edge with in_valid=0, sign/diff SHALL hold their previous values and out_valid SHALL be set to 0.
REQ-017 No backpressure; a new operand pair SHALL be accepted every cycle in_valid=1 (full throughput).
REQ-018 No internal overflow: diff SHALL never exceed 2^WIDTH-1 and SHALL not wrap.
REQ-019 X/Z on a or b with in_valid=1 need not produce defined results; outputs SHALL be defined whenever inputs are 0/1.

Reset
REQ-020 rst_n=0 SHALL immediately (without a clock edge) force out_valid=0, sign=0, diff=0.
REQ-021 While rst_n=0, outputs SHALL stay at reset values regardless of clk, in_valid, a, b.
REQ-022 A reset asserted mid-stream SHALL discard any pending result; after rst_n rises, the first clk edge with in_valid=1 SHALL produce a valid result one cycle later as per REQ-015.
REQ-023 Reset release SHALL be sampled safely: the first edge after deassertion behaves as a normal cycle.

Verification
REQ-024 Exhaustive sweep, WIDTH=2: all 16 (A,B) pairs, in_valid=1 each cycle -> each following cycle out_valid=1 with sign/diff per REQ-012/013 (e.g. A=0,B=1 -> sign 1, diff 01; A=3,B=0 -> sign 0, diff 11).
REQ-025 Corner: A=2,B=1 -> sign 0, diff 01; A=1,B=2 -> sign 1, diff 01.
REQ-026 Equality: A=B=3 -> sign 0, diff 00; A=B=0 -> sign 0, diff 00.
REQ-027 Hold: apply A=0,B=3 (result sign 1, diff 11), then in_valid=0 for 3 cycles with random a/b -> out_valid 0, sign 1, diff 11 held.
REQ-028 Async reset: pull rst_n low between clock edges while out_valid=1 -> out_valid, sign, diff go to 0 immediately; release, apply A=3,B=1 -> next cycle sign 0, diff 10, out_valid 1.
REQ-029 Back-to-back: alternate A=0,B=2 and A=2,B=0 each cycle -> diff stays 10, sign toggles 1,0,1,0 with one-cycle lag.

Source files
------------

// File: rtl/subtractor_binary_if.sv
// Operand/result bundle for the registered magnitude subtractor.
// The driver of the operands uses master; the subtractor itself uses slave.
interface subtractor_binary_if #(
   parameter int WIDTH = 2
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             sign;
   logic [WIDTH-1:0] diff;

   modport master (
      output in_valid, a, b,
      input  out_valid, sign, diff
   );

   modport slave (
      input  in_valid, a, b,
      output out_valid, sign, diff
   );
endinterface

// File: rtl/subtractor_binary.sv
// Unsigned sign/magnitude subtractor: sign = (A < B), diff = |A - B|,
// registered with one cycle of latency and full throughput.
module subtractor_binary #(
   parameter int WIDTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   subtractor_binary_if.slave bus
);

   logic [WIDTH-1:0] raw_diff;
   logic             bor;
   logic             a_lt_b;
   logic [WIDTH-1:0] mag;

   logic             out_valid_d, out_valid_q;
   logic             sign_d, sign_q;
   logic [WIDTH-1:0] diff_d, diff_q;

   // Ripple-borrow A - B; the final borrow is the unsigned A < B flag.
   // When it is set, negating the wrapped difference gives B - A exactly.
   always_comb begin
      raw_diff = '0;
      bor      = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         raw_diff[i] = bus.a[i] ^ bus.b[i] ^ bor;
         bor         = (~bus.a[i] & bus.b[i]) | (~(bus.a[i] ^ bus.b[i]) & bor);
      end
      a_lt_b = bor;
      mag    = a_lt_b ? (~raw_diff + WIDTH'(1)) : raw_diff;
   end

   always_comb begin
      out_valid_d = bus.in_valid;
      sign_d      = sign_q;
      diff_d      = diff_q;
      if (bus.in_valid) begin
         sign_d = a_lt_b;
         diff_d = mag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sign_q      <= 1'b0;
         diff_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         sign_q      <= sign_d;
         diff_q      <= diff_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.sign      = sign_q;
   assign bus.diff      = diff_q;

endmodule

// File: tb/tb_subtractor_binary.sv
// Self-checking bench for subtractor_binary: constant vector table, hand-written
// hold/reset/back-to-back sequences, and random traffic against an arithmetic model.
module tb_subtractor_binary;

   localparam int WIDTH = 2;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             expSign;
      logic [WIDTH-1:0] expDiff;
   } vector_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   // Behavioural model state: what the outputs should show right now.
   int   mValid;
   int   mSign;
   int   mDiff;

   vector_t vecs[16];

   subtractor_binary_if #(.WIDTH(WIDTH)) bus ();

   subtractor_binary #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached (actual=running required=finished)");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one cycle of operands, step past the rising edge, and advance the model.
   task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int ai;
      int bi;
      bus.in_valid = valid;
      bus.a        = a;
      bus.b        = b;
      ai = int'(a);
      bi = int'(b);
      @(posedge clk);
      #1;
      if (rst_n) begin
         mValid = valid ? 1 : 0;
         if (valid) begin
            mSign = (ai < bi) ? 1 : 0;
            mDiff = (ai >= bi) ? ai - bi : bi - ai;
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic expValid, input logic expSign,
                              input logic [WIDTH-1:0] expDiff);
      checks++;
      if (bus.out_valid !== expValid || bus.sign !== expSign || bus.diff !== expDiff) begin
         failures++;
         $display("[TB] FAIL %s: actual valid=%b sign=%b diff=%b required valid=%b sign=%b diff=%b",
                  name, bus.out_valid, bus.sign, bus.diff, expValid, expSign, expDiff);
      end
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, 1'(mValid), 1'(mSign), WIDTH'(mDiff));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      mValid   = 0;
      mSign    = 0;
      mDiff    = 0;

      vecs[0]  = '{2'd0, 2'd0, 1'b0, 2'd0};
      vecs[1]  = '{2'd0, 2'd1, 1'b1, 2'd1};
      vecs[2]  = '{2'd0, 2'd2, 1'b1, 2'd2};
      vecs[3]  = '{2'd0, 2'd3, 1'b1, 2'd3};
      vecs[4]  = '{2'd1, 2'd0, 1'b0, 2'd1};
      vecs[5]  = '{2'd1, 2'd1, 1'b0, 2'd0};
      vecs[6]  = '{2'd1, 2'd2, 1'b1, 2'd1};
      vecs[7]  = '{2'd1, 2'd3, 1'b1, 2'd2};
      vecs[8]  = '{2'd2, 2'd0, 1'b0, 2'd2};
      vecs[9]  = '{2'd2, 2'd1, 1'b0, 2'd1};
      vecs[10] = '{2'd2, 2'd2, 1'b0, 2'd0};
      vecs[11] = '{2'd2, 2'd3, 1'b1, 2'd1};
      vecs[12] = '{2'd3, 2'd0, 1'b0, 2'd3};
      vecs[13] = '{2'd3, 2'd1, 1'b0, 2'd2};
      vecs[14] = '{2'd3, 2'd2, 1'b0, 2'd1};
      vecs[15] = '{2'd3, 2'd3, 1'b0, 2'd0};

      // Reset state, including an edge with in_valid=1 while held in reset.
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.a        = 2'd3;
      bus.b        = 2'd0;
      #2;
      checkOutput("reset_initial", 1'b0, 1'b0, 2'd0);
      applyStimulus(1'b1, 2'd3, 2'd0);
      checkOutput("reset_held", 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Exhaustive sweep, one operand pair per cycle.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, vecs[i].a, vecs[i].b);
         checkOutput($sformatf("sweep_a%0d_b%0d", vecs[i].a, vecs[i].b), 1'b1, vecs[i].expSign, vecs[i].expDiff);
      end

      // Hold: result A=0,B=3 survives idle cycles with changing operands.
      applyStimulus(1'b1, 2'd0, 2'd3);
      checkOutput("hold_load", 1'b1, 1'b1, 2'd3);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         checkOutput($sformatf("hold_idle%0d", i), 1'b0, 1'b1, 2'd3);
      end

      // Async reset between edges while a result is valid.
      applyStimulus(1'b1, 2'd1, 2'd3);
      checkOutput("areset_pre", 1'b1, 1'b1, 2'd2);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("areset_immediate", 1'b0, 1'b0, 2'd0);
      mValid = 0;
      mSign  = 0;
      mDiff  = 0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 2'd3, 2'd1);
      checkOutput("areset_first_result", 1'b1, 1'b0, 2'd2);

      // Back-to-back alternating operands: diff constant, sign toggles.
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) applyStimulus(1'b1, 2'd0, 2'd2);
         else            applyStimulus(1'b1, 2'd2, 2'd0);
         checkOutput($sformatf("b2b_%0d", i), 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 2'd2);
      end

      // Random traffic with random gaps against the arithmetic model.
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         checkModel($sformatf("random_%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
